alu_exec: RTL and testbench
===========================

ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning the operand and result width in bits.
REQ-002 The block SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, meaning the asynchronous, active-low reset.
REQ-004 The block SHALL have port in_valid, input, 1, meaning a request is present.
REQ-005 The block SHALL have port in_ready, output, 1, meaning the block can accept a request this cycle.
REQ-006 The block SHALL have port Operation, input, 4, meaning the ALU operation code driven by the ALU control decoder.
REQ-007 The block SHALL have ports a and b, input, WIDTH each, meaning operand A and operand B.
REQ-008 The block SHALL have port out_valid, output, 1, meaning a result is present.
REQ-009 The block SHALL have port out_ready, input, 1, meaning the consumer accepts the result this cycle.
REQ-010 The block SHALL have port result, output, WIDTH, meaning the operation result.
REQ-011 The block SHALL have port zero, output, 1, meaning result equals 0.
REQ-012 The block SHALL have port overflow, output, 1, meaning signed overflow on ADD or SUB.
REQ-013 The block SHALL have port illegal, output, 1, meaning the Operation code is unsupported.
REQ-014 The block SHALL have port op_count, output, 16, meaning the number of accepted requests.

Function
REQ-015 Operation decode SHALL be: 0000 AND; 0001 OR; 0010 ADD; 0110 SUB (a-b); 0111 SLT (signed a<b gives 1, else 0); 1100 NOR.
REQ-016 Any other code SHALL give result 0, zero 1, overflow 0 and illegal 1.
REQ-017 ADD and SUB SHALL be modulo 2^WIDTH, with the carry-out discarded.
REQ-018 overflow SHALL be 1 only for ADD or SUB with signed overflow, otherwise 0.
REQ-019 SLT SHALL give the true signed comparison even when a-b overflows (e.g. a=0x80000000, b=1 gives 1).
REQ-020 A request SHALL be accepted when in_valid and in_ready are both 1 at a clock edge; Operation, a and b are sampled only on that edge.
REQ-021 Latency SHALL be 1 cycle: an accepted request appears with out_valid=1 in the next cycle.
REQ-022 A result SHALL be consumed when out_valid and out_ready are both 1 at a clock edge.
REQ-023 Storage SHALL be two entries: an output register (OUT) plus a skid register (SKID); results retire in acceptance order.
REQ-024 in_ready SHALL equal NOT SKID-full, registered state only, with no combinational path from out_ready.
REQ-025 While out_valid=1 and out_ready=0, result, zero, overflow and illegal SHALL hold stable.
REQ-026 States SHALL be: EMPTY (OUT and SKID empty), ONE (OUT full), TWO (OUT and SKID full).
REQ-027 EMPTY SHALL go to ONE on accept.
REQ-028 ONE SHALL stay in ONE on accept and consume together (OUT is reloaded), go to TWO on accept without consume (new result to SKID), and go to EMPTY on consume without accept.
REQ-029 TWO SHALL go to ONE on consume (SKID moves to OUT); in_ready is 0 in TWO, so no accept occurs.
REQ-030 Throughput SHALL be 1 result per cycle while out_ready is held at 1.
REQ-031 op_count SHALL increment by 1 per accepted request, legal or illegal, and wrap from 0xFFFF to 0x0000.
REQ-032 When in_valid is 0, a and b SHALL have no effect on any output.

Reset
REQ-033 Asserting rst_n low SHALL immediately force the EMPTY state, out_valid 0, result 0, zero 0, overflow 0, illegal 0, op_count 0 and in_ready 1.
REQ-034 Reset asserted mid-operation SHALL drop in-flight results without emitting them, and the first accept after reset SHALL give op_count 1.
REQ-035 The deassertion of rst_n SHALL be synchronised to clk by the integrating design; the block SHALL accept a request on the first edge after deassertion.

Verification
REQ-036 The bench SHALL cover: ADD a=0x7FFFFFFF, b=1, out_ready=1 -> next cycle result 0x80000000, overflow 1, zero 0.
REQ-037 The bench SHALL cover: SUB a=5, b=5 -> result 0, zero 1, overflow 0; then SLT a=0xFFFFFFFF, b=0 -> result 1.
REQ-038 The bench SHALL cover: three back-to-back accepts with out_ready=0 -> in_ready drops to 0 after the second accept and the third is held off; raising out_ready then retires results in order with no loss.
REQ-039 The bench SHALL cover: Operation=1111, a=3, b=4 -> result 0, zero 1, illegal 1, op_count incremented.
REQ-040 The bench SHALL cover: reset asserted while in state TWO -> out_valid 0 and in_ready 1 immediately, op_count 0, and no stale result after release.
REQ-041 The bench SHALL cover: 65536 accepts -> op_count wraps to 0x0000.

Source files
------------

// File: rtl/alu_exec.sv
// alu_exec: single-cycle ALU with a two-entry valid/ready output stage.
//
// Ports:
//   clk, rst_n          - clock (rising edge) and asynchronous active-low reset
//   in_valid, in_ready  - request handshake; in_ready is registered state only
//   Operation, a, b     - operation code and operands, sampled on accept
//   out_valid, out_ready- result handshake
//   result, zero        - operation result and result==0 flag
//   overflow, illegal   - signed overflow on ADD/SUB; unsupported Operation code
//   op_count            - number of accepted requests (wraps at 16 bits)
module alu_exec #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       Operation,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             overflow,
   output logic             illegal,
   output logic [15:0]      op_count
);

   localparam logic [3:0] OpAnd = 4'b0000;
   localparam logic [3:0] OpOr  = 4'b0001;
   localparam logic [3:0] OpAdd = 4'b0010;
   localparam logic [3:0] OpSub = 4'b0110;
   localparam logic [3:0] OpSlt = 4'b0111;
   localparam logic [3:0] OpNor = 4'b1100;

   // Entry layout: {illegal, overflow, zero, result}
   localparam int unsigned EntryW = WIDTH + 3;

   typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

   state_e              state_q, state_d;
   logic [EntryW-1:0]   out_q, skid_q;
   logic [15:0]         op_count_q;

   logic [WIDTH-1:0]    sum, diff, res;
   logic                ovf, ill, slt;
   logic [EntryW-1:0]   entry_new;
   logic                accept, consume;
   logic                load_out_new, load_out_skid, load_skid;

   // Datapath
   always_comb begin
      sum  = a + b;
      diff = a - b;
      // Direct signed compare, so SLT stays correct when a-b overflows.
      slt  = $signed(a) < $signed(b);
      res  = '0;
      ovf  = 1'b0;
      ill  = 1'b0;
      case (Operation)
         OpAnd: res = a & b;
         OpOr:  res = a | b;
         OpAdd: begin
            res = sum;
            ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
         end
         OpSub: begin
            res = diff;
            ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
         end
         OpSlt: res = {{(WIDTH-1){1'b0}}, slt};
         OpNor: res = ~(a | b);
         default: ill = 1'b1;
      endcase
      entry_new = {ill, ovf, (res == '0), res};
   end

   assign in_ready  = (state_q != StTwo);
   assign out_valid = (state_q != StEmpty);
   assign accept    = in_valid & in_ready;
   assign consume   = out_valid & out_ready;

   // Next-state and register load selects
   always_comb begin
      state_d       = state_q;
      load_out_new  = 1'b0;
      load_out_skid = 1'b0;
      load_skid     = 1'b0;
      unique case (state_q)
         StEmpty: begin
            if (accept) begin
               load_out_new = 1'b1;
               state_d      = StOne;
            end
         end
         StOne: begin
            if (accept && consume) begin
               load_out_new = 1'b1;
            end else if (accept) begin
               load_skid = 1'b1;
               state_d   = StTwo;
            end else if (consume) begin
               state_d = StEmpty;
            end
         end
         StTwo: begin
            if (consume) begin
               load_out_skid = 1'b1;
               state_d       = StOne;
            end
         end
         default: state_d = StEmpty;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StEmpty;
         out_q      <= '0;
         skid_q     <= '0;
         op_count_q <= '0;
      end else begin
         state_q <= state_d;
         if (load_out_new) begin
            out_q <= entry_new;
         end else if (load_out_skid) begin
            out_q <= skid_q;
         end
         if (load_skid) begin
            skid_q <= entry_new;
         end
         if (accept) begin
            op_count_q <= op_count_q + 16'd1;
         end
      end
   end

   assign result   = out_q[WIDTH-1:0];
   assign zero     = out_q[WIDTH];
   assign overflow = out_q[WIDTH+1];
   assign illegal  = out_q[WIDTH+2];
   assign op_count = op_count_q;

endmodule

// File: tb/tb_alu_exec.sv
// tb_alu_exec: directed stimulus with a queue-based reference model checked every cycle,
// plus hand-computed literal expectations at key points.
module tb_alu_exec;

   localparam int unsigned W = 32;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [3:0]    op = 4'b0000;
   logic [W-1:0]  a = '0;
   logic [W-1:0]  b = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [W-1:0]  result;
   logic          zero;
   logic          overflow;
   logic          illegal;
   logic [15:0]   op_count;

   int vectors = 0;
   int errors  = 0;

   always #5 clk = ~clk;

   alu_exec #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .Operation (op),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .zero      (zero),
      .overflow  (overflow),
      .illegal   (illegal),
      .op_count  (op_count)
   );

   typedef struct {
      logic [W-1:0] r;
      bit           z;
      bit           ov;
      bit           ill;
   } exp_t;

   exp_t      q[$];
   bit [15:0] mcount = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: arithmetic on 64-bit signed values, overflow judged by range.
   function automatic exp_t model(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
      exp_t   e;
      longint sx = longint'($signed(x));
      longint sy = longint'($signed(y));
      longint s;
      e.r = '0; e.ov = 0; e.ill = 0;
      case (o)
         4'd0:  e.r = x & y;
         4'd1:  e.r = x | y;
         4'd2: begin
            s = sx + sy; e.r = s[W-1:0];
            e.ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
         end
         4'd6: begin
            s = sx - sy; e.r = s[W-1:0];
            e.ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
         end
         4'd7:  e.r = (sx < sy) ? 32'd1 : 32'd0;
         4'd12: e.r = ~(x | y);
         default: e.ill = 1;
      endcase
      e.z = (e.r == 0);
      return e;
   endfunction

   // Model state update on the same edges as the DUT.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q.delete();
         mcount = '0;
      end else begin
         bit acc, con;
         acc = in_valid && (q.size() < 2);
         con = (q.size() > 0) && out_ready;
         if (con) void'(q.pop_front());
         if (acc) begin
            q.push_back(model(op, a, b));
            mcount = mcount + 16'd1;
         end
      end
   end

   // Per-cycle comparison, away from the active edge.
   always @(negedge clk) begin
      if (rst_n) begin
         chk("in_ready", in_ready, (q.size() < 2));
         chk("out_valid", out_valid, (q.size() > 0));
         chk("op_count", op_count, mcount);
         if (q.size() > 0) begin
            chk("result", result, q[0].r);
            chk("zero", zero, q[0].z);
            chk("overflow", overflow, q[0].ov);
            chk("illegal", illegal, q[0].ill);
         end
      end
   end

   task automatic step(input bit v, input logic [3:0] o, input logic [W-1:0] x,
                       input logic [W-1:0] y, input bit r);
      in_valid = v; op = o; a = x; b = y; out_ready = r;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #3 rst_n = 1'b0;
      #1;
      chk("rst out_valid", out_valid, 0);
      chk("rst in_ready", in_ready, 1);
      chk("rst result", result, 0);
      chk("rst flags", {zero, overflow, illegal}, 0);
      chk("rst op_count", op_count, 0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;

      // Arithmetic corners, full throughput
      step(1, 4'b0010, 32'h7FFF_FFFF, 32'd1, 1);
      chk("add result", result, 32'h8000_0000);
      chk("add ovf/zero", {overflow, zero}, 2'b10);
      step(1, 4'b0110, 32'd5, 32'd5, 1);
      chk("sub result", result, 0);
      chk("sub zero/ovf", {zero, overflow}, 2'b10);
      step(1, 4'b0111, 32'hFFFF_FFFF, 32'd0, 1);
      chk("slt -1<0", result, 1);
      step(1, 4'b1111, 32'd3, 32'd4, 1);
      chk("illegal result", result, 0);
      chk("illegal zero/ill", {zero, illegal}, 2'b11);
      chk("illegal op_count", op_count, 4);
      step(1, 4'b0111, 32'h8000_0000, 32'd1, 1);
      chk("slt min<1", result, 1);
      step(0, 4'b0010, 32'hDEAD_BEEF, 32'h1234_5678, 1);
      chk("drained", out_valid, 0);

      // Backpressure: fill both entries, third held off
      step(1, 4'b0000, 32'hF0, 32'h3C, 0);
      chk("bp1 result", result, 32'h30);
      chk("bp1 in_ready", in_ready, 1);
      step(1, 4'b0001, 32'hF0, 32'h0F, 0);
      chk("bp2 in_ready", in_ready, 0);
      chk("bp2 hold", result, 32'h30);
      step(1, 4'b1100, 32'd0, 32'd0, 0);
      chk("bp3 held", in_ready, 0);
      chk("bp3 op_count", op_count, 7);
      step(1, 4'b1100, 32'd0, 32'd0, 1);
      chk("bp retire or", result, 32'hFF);
      chk("bp op_count", op_count, 7);
      step(1, 4'b1100, 32'd0, 32'd0, 1);
      chk("bp retire nor", result, 32'hFFFF_FFFF);
      chk("bp op_count2", op_count, 8);
      step(0, 4'b0000, 32'd0, 32'd0, 1);
      chk("bp drained", out_valid, 0);

      // Reset while two results are held
      step(1, 4'b0010, 32'd1, 32'd2, 0);
      step(1, 4'b0010, 32'd3, 32'd4, 0);
      chk("two in_ready", in_ready, 0);
      #2 rst_n = 1'b0;
      #1;
      chk("mid-rst out_valid", out_valid, 0);
      chk("mid-rst in_ready", in_ready, 1);
      chk("mid-rst op_count", op_count, 0);
      @(negedge clk) rst_n = 1'b1;
      step(0, 4'b0010, 32'd0, 32'd0, 1);
      chk("no stale", out_valid, 0);
      step(1, 4'b0010, 32'd10, 32'd20, 1);
      chk("post-rst result", result, 32'd30);
      chk("post-rst op_count", op_count, 1);

      // Counter wrap: 65536 accepts since reset
      for (int i = 0; i < 65534; i++) begin
         step(1, 4'b0010, i, 32'd1, 1);
      end
      chk("count ffff", op_count, 16'hFFFF);
      step(1, 4'b0001, 32'd0, 32'd0, 1);
      chk("count wrap", op_count, 16'h0000);
      step(0, 4'b0000, 32'd0, 32'd0, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
